kanade_mem_arbiter: RTL and testbench
=====================================

// Module: kanade_mem_arbiter
// PURPOSE
// - Arbitrates N requesters (fetch, load/store, later DMA/debug) onto one single-port synchronous RAM.
//   It replaces the static fetch/data address mux used by the multi-cycle core.
// - Allows fetch and memory-access stages to issue every cycle in the pipelined core.
// - Supports fixed-priority or round-robin grant, pipelined read-return tagging for RAM_LATENCY >= 1,
//   and a global hold from pipeline control.
// PARAMETERS
// - N_PORTS     2   number of requesters; port 0 = highest fixed priority (load/store)
// - ADDR_W      32  byte-address width
// - DATA_W      32  data width; RAM word = DATA_W bits
// - RAM_LATENCY 1   cycles from ram_address/ram_wren to valid ram_q (1..4)
// - PRIO_MODE   0   0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
// - clk          in   1                  clock
// - reset_n      in   1                  asynchronous active-low reset
// - hold         in   1                  1 = issue no new grants this cycle; in-flight reads still return
// - req          in   N_PORTS            per-port request; addr/we/wdata stable while req=1 and gnt=0
// - we           in   N_PORTS            per-port write enable (1 = write, 0 = read)
// - addr         in   N_PORTS*ADDR_W     packed byte addresses; port p at [p*ADDR_W +: ADDR_W]
// - wdata        in   N_PORTS*DATA_W     packed write data
// - gnt          out  N_PORTS            one-hot accept; transfer happens when req[p]&gnt[p]
// - rvalid       out  N_PORTS            read data valid for port p, one cycle
// - rdata        out  DATA_W             read data, broadcast to all ports; qualify with rvalid
// - rd_pending   out  $clog2(RAM_LATENCY+1)  number of granted reads not yet returned
// - ram_address  out  ADDR_W-2           word address (addr[ADDR_W-1:2]); addr[1:0] is ignored
// - ram_data     out  DATA_W             RAM write data
// - ram_wren     out  1                  RAM write strobe
// - ram_q        in   DATA_W             RAM read data
// BEHAVIOUR
// - Reset (async, reset_n=0):
//   - State: tag pipeline cleared; RR pointer = 0; rd_pending = 0.
//   - Outputs: gnt, rvalid, ram_wren = 0; ram_address, ram_data, rdata = 0.
//   - In-flight reads are dropped and never signalled.
// - Grant is combinational and occurs in the same cycle as req.
//   - gnt = 0 when hold=1 or reset_n=0.
//   - Otherwise exactly one gnt bit is set iff any req is set. Never two bits.
// - Selection:
//   - PRIO_MODE=0: lowest-indexed requesting port.
//   - PRIO_MODE=1: first requesting port at or after rr_ptr, wrapping mod N_PORTS.
//     On a grant to port p, rr_ptr <= (p+1) mod N_PORTS. rr_ptr is unchanged with no grant or under hold.
// - Issue cycle (gnt[p]=1):
//   - ram_address = addr_p[ADDR_W-1:2]; ram_data = wdata_p; ram_wren = we[p].
//   - With no grant: ram_address = 0, ram_data = 0, ram_wren = 0.
// - Writes complete at grant and produce no rvalid.
// - Reads: tag {valid, port_id} enters a RAM_LATENCY-deep shift register.
//   - When the tag exits, rvalid[port_id] = 1 and rdata = ram_q.
//   - rdata = 0 when no rvalid is set.
//   - Read latency from grant to rvalid = exactly RAM_LATENCY cycles.
// - Throughput: one grant per cycle, back-to-back, any read/write mix.
//   - Read-after-write to the same address in consecutive cycles returns the new data (RAM write-first order).
// - rd_pending: +1 on a read grant, -1 on rvalid. Both in the same cycle leave it unchanged.
//   - It cannot exceed RAM_LATENCY.
// - Request withdrawal: req may drop before gnt with no side effect. Dropping req after gnt is a new request.
// - Hold mid-stream: in-flight reads still return on schedule. Held requesters keep req asserted.
// - Only one port is active, in either mode: it is granted every cycle it requests.
// STRUCTURE
// - kanade_pkg: PRIO_FIXED=0, PRIO_RR=1 constants; function clog2 shared with other kanade blocks.
// - Sub-module kanade_rr_pick (N, mode): req vector + pointer -> one-hot grant + encoded index.
// - Top level holds the tag shift register, rr_ptr, rd_pending counter and output muxes.
// TESTING
// - Reset: reset_n=0 with req=2'b11 -> gnt=0, ram_wren=0, rvalid=0, rd_pending=0.
// - Fixed priority, LAT=1: req=2'b11, both reads, addr0=0x10, addr1=0x20 -> gnt=2'b01, ram_address=0x4.
//   - Next cycle: rvalid=2'b01, rdata=mem[4].
//   - Port 1 is starved while port 0 keeps requesting.
// - Round-robin: req=2'b11 held 4 cycles -> gnt sequence 01,10,01,10; rr_ptr wraps to 0.
// - Pipelined reads, LAT=3: port1 reads words 1,2,3 back-to-back -> rvalid[1] in cycles 3,4,5 with mem[1..3].
//   - rd_pending peaks at 3.
// - Write-then-read: port0 writes 0xDEADBEEF to 0x40, then reads 0x40 next cycle.
//   - Result: ram_wren pulse in the first cycle; rvalid[0] with rdata=0xDEADBEEF after LAT.
// - Hold + reset mid-op: hold=1 for 2 cycles with reads in flight -> gnt=0 but rvalid still fires.
//   - reset_n pulsed with rd_pending=2 -> no rvalid afterwards, rd_pending=0.

Source files
------------

// File: rtl/kanade_pkg.sv
// kanade_pkg: shared arbitration mode constants and helpers for kanade blocks
package kanade_pkg;
  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/kanade_rr_pick.sv
// kanade_rr_pick: picks one requester, lowest index or first at/after a rotating pointer
module kanade_rr_pick
  import kanade_pkg::*;
#(
  parameter int N    = 2,
  parameter int MODE = PRIO_FIXED,
  parameter int IW   = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic found;
  logic [IW-1:0] j;
  // scan ports in priority order starting at index 0 or at the pointer
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = (MODE == PRIO_RR) ? IW'((int'(ptr_i) + k) % N) : IW'(k);
      if (!found && req_i[j]) begin
        found = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/kanade_mem_arbiter.sv
// kanade_mem_arbiter: shares one single-port synchronous RAM among N requesters with tagged read return
module kanade_mem_arbiter
  import kanade_pkg::*;
#(
  parameter int N_PORTS     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 1,
  parameter int PRIO_MODE   = PRIO_FIXED
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              hold,
  input  logic [N_PORTS-1:0]                req,
  input  logic [N_PORTS-1:0]                we,
  input  logic [N_PORTS*ADDR_W-1:0]         addr,
  input  logic [N_PORTS*DATA_W-1:0]         wdata,
  output logic [N_PORTS-1:0]                gnt,
  output logic [N_PORTS-1:0]                rvalid,
  output logic [DATA_W-1:0]                 rdata,
  output logic [clog2(RAM_LATENCY+1)-1:0]   rd_pending,
  output logic [ADDR_W-3:0]                 ram_address,
  output logic [DATA_W-1:0]                 ram_data,
  output logic                              ram_wren,
  input  logic [DATA_W-1:0]                 ram_q
);
  localparam int IW = (N_PORTS > 1) ? clog2(N_PORTS) : 1;
  localparam int PW = clog2(RAM_LATENCY + 1);
  logic [N_PORTS-1:0] pick_gnt;
  logic [IW-1:0] pick_idx, rr_q, rr_d;
  logic [RAM_LATENCY-1:0] tv_q;
  logic [RAM_LATENCY:0] tv_d;
  logic [RAM_LATENCY-1:0][IW-1:0] tp_q;
  logic [RAM_LATENCY:0][IW-1:0] tp_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic issue, rd_issue, ret;

  kanade_rr_pick #(.N(N_PORTS), .MODE(PRIO_MODE), .IW(IW)) u_pick (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // gated grant, RAM issue mux, tag exit decode and next-state for pointer, tags and counter
  always_comb begin
    issue = reset_n && !hold && |req;
    gnt = issue ? pick_gnt : '0;
    ram_address = issue ? addr[int'(pick_idx)*ADDR_W+2 +: ADDR_W-2] : '0;
    ram_data = issue ? wdata[int'(pick_idx)*DATA_W +: DATA_W] : '0;
    ram_wren = issue && we[pick_idx];
    rd_issue = issue && !we[pick_idx];
    ret = tv_q[RAM_LATENCY-1];
    rvalid = ret ? N_PORTS'(1) << tp_q[RAM_LATENCY-1] : '0;
    rdata = ret ? ram_q : '0;
    tv_d = {tv_q, rd_issue};
    tp_d = {tp_q, pick_idx};
    rr_d = !issue ? rr_q : (int'(pick_idx) == N_PORTS - 1) ? '0 : pick_idx + 1'b1;
    cnt_d = cnt_q + PW'(rd_issue) - PW'(ret);
  end

  // tag shift register, round-robin pointer and outstanding-read counter; reset drops in-flight reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tv_q <= '0;
      tp_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
    end else begin
      tv_q <= tv_d[RAM_LATENCY-1:0];
      tp_q <= tp_d[RAM_LATENCY-1:0];
      rr_q <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd_pending = cnt_q;
endmodule

// File: tb/tb_kanade_mem_arbiter.sv
// tb_kanade_mem_arbiter: directed checks of fixed, round-robin and latency-3 arbiter instances
module tb_kanade_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int n_run = 0;
  int n_fail = 0;

  logic f_hold, r_hold, s_hold;
  logic [1:0] f_req, f_we, r_req, r_we, s_req, s_we;
  logic [63:0] f_addr, f_wdata, r_addr, r_wdata, s_addr, s_wdata;
  logic [1:0] f_gnt, f_rvalid, r_gnt, r_rvalid, s_gnt, s_rvalid;
  logic [31:0] f_rdata, r_rdata, s_rdata, f_rd, r_rd, s_rd, f_q, r_q, s_q;
  logic [0:0] f_rdp, r_rdp;
  logic [1:0] s_rdp;
  logic [29:0] f_ra, r_ra, s_ra;
  logic f_wren, r_wren, s_wren;
  logic [31:0] s_q1, s_q2, s_wd;
  logic [29:0] s_wa;
  logic s_wv = 1'b0;

  always #5 clk = ~clk;

  kanade_mem_arbiter #(.RAM_LATENCY(1), .PRIO_MODE(0)) u_f (
    .clk(clk), .reset_n(reset_n), .hold(f_hold), .req(f_req), .we(f_we), .addr(f_addr),
    .wdata(f_wdata), .gnt(f_gnt), .rvalid(f_rvalid), .rdata(f_rdata), .rd_pending(f_rdp),
    .ram_address(f_ra), .ram_data(f_rd), .ram_wren(f_wren), .ram_q(f_q));
  kanade_mem_arbiter #(.RAM_LATENCY(1), .PRIO_MODE(1)) u_r (
    .clk(clk), .reset_n(reset_n), .hold(r_hold), .req(r_req), .we(r_we), .addr(r_addr),
    .wdata(r_wdata), .gnt(r_gnt), .rvalid(r_rvalid), .rdata(r_rdata), .rd_pending(r_rdp),
    .ram_address(r_ra), .ram_data(r_rd), .ram_wren(r_wren), .ram_q(r_q));
  kanade_mem_arbiter #(.RAM_LATENCY(3), .PRIO_MODE(0)) u_s (
    .clk(clk), .reset_n(reset_n), .hold(s_hold), .req(s_req), .we(s_we), .addr(s_addr),
    .wdata(s_wdata), .gnt(s_gnt), .rvalid(s_rvalid), .rdata(s_rdata), .rd_pending(s_rdp),
    .ram_address(s_ra), .ram_data(s_rd), .ram_wren(s_wren), .ram_q(s_q));

  // RAM models: unwritten word w reads as A000_0000|w; the latency-3 RAM remembers its last write
  always @(posedge clk) f_q <= 32'hA000_0000 | {2'b00, f_ra};
  always @(posedge clk) r_q <= 32'hA000_0000 | {2'b00, r_ra};
  always @(posedge clk) begin
    if (s_wren) begin
      s_wa <= s_ra;
      s_wd <= s_rd;
      s_wv <= 1'b1;
    end
    s_q1 <= s_wren ? s_rd : (s_wv && s_wa == s_ra) ? s_wd : (32'hA000_0000 | {2'b00, s_ra});
    s_q2 <= s_q1;
    s_q <= s_q2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    {f_hold, r_hold, s_hold} = '0;
    {f_req, r_req, s_req} = {2'b11, 2'b11, 2'b11};
    {f_we, r_we, s_we} = '0;
    {f_addr, r_addr, s_addr} = '0;
    {f_wdata, r_wdata, s_wdata} = '0;
    #3;
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_f_wren", f_wren, 0);
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_f_rdp", f_rdp, 0);
    chk("rst_f_ra", f_ra, 0);
    chk("rst_r_gnt", r_gnt, 0);
    chk("rst_s_gnt", s_gnt, 0);
    chk("rst_s_rdp", s_rdp, 0);
    nxt;
    {f_req, r_req, s_req} = '0;
    reset_n = 1'b1;
    nxt;
    // fixed priority, latency 1
    f_req = 2'b11;
    f_addr = {32'h20, 32'h13};
    #1;
    chk("fix0_gnt", f_gnt, 2'b01);
    chk("fix0_ra", f_ra, 4);
    chk("fix0_wren", f_wren, 0);
    chk("fix0_rvalid", f_rvalid, 0);
    nxt; #1;
    chk("fix1_rvalid", f_rvalid, 2'b01);
    chk("fix1_rdata", f_rdata, 32'hA000_0004);
    chk("fix1_starve", f_gnt, 2'b01);
    chk("fix1_rdp", f_rdp, 1);
    nxt; f_req = 2'b10; #1;
    chk("fix2_gnt", f_gnt, 2'b10);
    chk("fix2_ra", f_ra, 8);
    chk("fix2_rvalid", f_rvalid, 2'b01);
    nxt; f_req = 2'b00; #1;
    chk("fix3_gnt", f_gnt, 0);
    chk("fix3_ra", f_ra, 0);
    chk("fix3_rvalid", f_rvalid, 2'b10);
    chk("fix3_rdata", f_rdata, 32'hA000_0008);
    chk("fix3_rdp", f_rdp, 1);
    nxt; #1;
    chk("fix4_rvalid", f_rvalid, 0);
    chk("fix4_rdata", f_rdata, 0);
    chk("fix4_rdp", f_rdp, 0);
    // round-robin, latency 1
    nxt; r_req = 2'b11; r_addr = {32'h20, 32'h10}; #1;
    chk("rr0_gnt", r_gnt, 2'b01);
    nxt; #1;
    chk("rr1_gnt", r_gnt, 2'b10);
    chk("rr1_ra", r_ra, 8);
    chk("rr1_rvalid", r_rvalid, 2'b01);
    chk("rr1_rdata", r_rdata, 32'hA000_0004);
    nxt; #1;
    chk("rr2_gnt", r_gnt, 2'b01);
    chk("rr2_rvalid", r_rvalid, 2'b10);
    chk("rr2_rdata", r_rdata, 32'hA000_0008);
    nxt; #1;
    chk("rr3_gnt", r_gnt, 2'b10);
    nxt; r_req = 2'b10; #1;
    chk("rr4_single", r_gnt, 2'b10);
    nxt; r_req = 2'b01; #1;
    chk("rr5_single", r_gnt, 2'b01);
    nxt; r_req = 2'b11; r_hold = 1'b1; #1;
    chk("rr6_hold_gnt", r_gnt, 0);
    chk("rr6_hold_rvalid", r_rvalid, 2'b01);
    nxt; r_hold = 1'b0; #1;
    chk("rr7_ptr_kept", r_gnt, 2'b10);
    nxt; r_req = 2'b00; #1;
    chk("rr8_gnt", r_gnt, 0);
    chk("rr8_rvalid", r_rvalid, 2'b10);
    // latency 3, port 1 reads words 1..3 back-to-back
    nxt; s_req = 2'b10; s_addr = {32'h4, 32'h0}; #1;
    chk("l3_0_gnt", s_gnt, 2'b10);
    chk("l3_0_ra", s_ra, 1);
    chk("l3_0_rdp", s_rdp, 0);
    nxt; s_addr = {32'h8, 32'h0}; #1;
    chk("l3_1_rdp", s_rdp, 1);
    chk("l3_1_rvalid", s_rvalid, 0);
    chk("l3_1_ra", s_ra, 2);
    nxt; s_addr = {32'hC, 32'h0}; #1;
    chk("l3_2_rdp", s_rdp, 2);
    chk("l3_2_rvalid", s_rvalid, 0);
    nxt; s_req = 2'b00; #1;
    chk("l3_3_rvalid", s_rvalid, 2'b10);
    chk("l3_3_rdata", s_rdata, 32'hA000_0001);
    chk("l3_3_rdp", s_rdp, 3);
    nxt; #1;
    chk("l3_4_rvalid", s_rvalid, 2'b10);
    chk("l3_4_rdata", s_rdata, 32'hA000_0002);
    chk("l3_4_rdp", s_rdp, 2);
    nxt; #1;
    chk("l3_5_rvalid", s_rvalid, 2'b10);
    chk("l3_5_rdata", s_rdata, 32'hA000_0003);
    chk("l3_5_rdp", s_rdp, 1);
    nxt; #1;
    chk("l3_6_rvalid", s_rvalid, 0);
    chk("l3_6_rdp", s_rdp, 0);
    // write then read the same word
    nxt; s_req = 2'b01; s_we = 2'b01; s_addr = {32'h0, 32'h40}; s_wdata = {32'h0, 32'hDEAD_BEEF}; #1;
    chk("wr0_gnt", s_gnt, 2'b01);
    chk("wr0_wren", s_wren, 1);
    chk("wr0_data", s_rd, 32'hDEAD_BEEF);
    chk("wr0_ra", s_ra, 16);
    nxt; s_we = 2'b00; #1;
    chk("rd1_gnt", s_gnt, 2'b01);
    chk("rd1_wren", s_wren, 0);
    chk("rd1_rdp", s_rdp, 0);
    nxt; s_req = 2'b00; #1;
    chk("rd2_rdp", s_rdp, 1);
    nxt; #1;
    chk("rd3_rvalid", s_rvalid, 0);
    nxt; #1;
    chk("rd4_rvalid", s_rvalid, 2'b01);
    chk("rd4_rdata", s_rdata, 32'hDEAD_BEEF);
    nxt; #1;
    chk("rd5_rdp", s_rdp, 0);
    // hold with reads in flight, then reset mid-operation
    nxt; s_req = 2'b01; s_addr = {32'h0, 32'h10}; #1;
    chk("h0_gnt", s_gnt, 2'b01);
    nxt; #1;
    nxt; s_hold = 1'b1; #1;
    chk("h2_gnt", s_gnt, 0);
    chk("h2_ra", s_ra, 0);
    chk("h2_rdp", s_rdp, 2);
    nxt; #1;
    chk("h3_gnt", s_gnt, 0);
    chk("h3_rvalid", s_rvalid, 2'b01);
    chk("h3_rdata", s_rdata, 32'hA000_0004);
    chk("h3_rdp", s_rdp, 2);
    nxt; s_hold = 1'b0; #1;
    chk("h4_gnt", s_gnt, 2'b01);
    chk("h4_rvalid", s_rvalid, 2'b01);
    chk("h4_rdp", s_rdp, 1);
    nxt; #1;
    chk("h5_rvalid", s_rvalid, 0);
    chk("h5_rdp", s_rdp, 1);
    nxt; s_req = 2'b00; #1;
    chk("h6_rdp", s_rdp, 2);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_rdp", s_rdp, 0);
    chk("rst_mid_rvalid", s_rvalid, 0);
    nxt;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt; #1;
      chk("post_rst_rvalid", s_rvalid, 0);
      chk("post_rst_rdp", s_rdp, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
